// File: rtl/uart_packetizer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_packetizer_fsm
//  Description : Pops bytes from a show-ahead FIFO, collects up to
//                MAX_PAYLOAD of them and emits a SOF / LEN / payload / CHK
//                packet on a valid/ready byte stream toward the UART TX.
//                A partial packet is closed after TIMEOUT_CYCLES idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_packetizer_fsm #(
  parameter int             DATA_WIDTH     = 8,
  parameter int             MAX_PAYLOAD    = 8,
  parameter int             TIMEOUT_CYCLES = 64,
  parameter logic [7:0]     SOF_BYTE       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [15:0]           pkt_count
);

  // Buffer index width; a one-entry buffer still needs a 1-bit index.
  localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  // Timer must be able to hold the value TIMEOUT_CYCLES itself.
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]       MAX_CNT = 8'(MAX_PAYLOAD);
  localparam logic [TMR_W-1:0] TMO     = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_SOF     = 3'd2,
    S_LEN     = 3'd3,
    S_PAYLOAD = 3'd4,
    S_CHK     = 3'd5
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              cnt;
  logic [7:0]              idx;
  logic [TMR_W-1:0]        timer;
  logic [DATA_WIDTH-1:0]   chk_acc;
  logic [DATA_WIDTH-1:0]   payload_buf [MAX_PAYLOAD];
  logic                    pop;
  logic                    accept;

  assign pop    = fifo_rd_en && fifo_valid;
  assign accept = tx_valid && tx_ready;
  assign busy   = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state output muxing.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    case (state)
      S_IDLE: begin
        fifo_rd_en = fifo_valid;
        if (fifo_valid) begin
          state_nxt = (MAX_CNT == 8'd1) ? S_SOF : S_COLLECT;
        end
      end
      S_COLLECT: begin
        fifo_rd_en = fifo_valid && (cnt < MAX_CNT);
        if (fifo_rd_en) begin
          // A pop always wins over a simultaneous timer expiry.
          if ((cnt + 8'd1) == MAX_CNT) begin
            state_nxt = S_SOF;
          end
        end else if ((timer + TMR_W'(1)) == TMO) begin
          state_nxt = S_SOF;
        end
      end
      S_SOF: begin
        tx_valid = 1'b1;
        tx_data  = SOF_BYTE;
        if (tx_ready) begin
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        tx_valid = 1'b1;
        tx_data  = cnt;
        if (tx_ready) begin
          state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = payload_buf[idx[IDX_W-1:0]];
        if (tx_ready && (idx == (cnt - 8'd1))) begin
          state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        tx_valid = 1'b1;
        tx_data  = chk_acc ^ cnt;
        if (tx_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // IDLE is the reset state, so the pop request must be masked while
    // reset is held or a waiting FIFO byte would be requested.
    fifo_rd_en = fifo_rd_en && rst_n;
  end

  // Byte count, running checksum, idle timer, payload index and packet stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      timer     <= '0;
      chk_acc   <= '0;
      pkt_done  <= 1'b0;
      pkt_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (pop) begin
        cnt     <= cnt + 8'd1;
        chk_acc <= chk_acc ^ fifo_data;
        timer   <= '0;
      end else if (state == S_COLLECT) begin
        timer <= timer + TMR_W'(1);
      end
      if (accept) begin
        case (state)
          S_LEN:     idx <= '0;
          S_PAYLOAD: idx <= idx + 8'd1;
          S_CHK: begin
            pkt_done  <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
            cnt       <= '0;
            chk_acc   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Payload storage; contents are don't-care until cnt says otherwise.
  always_ff @(posedge clk) begin
    if (pop) begin
      payload_buf[cnt[IDX_W-1:0]] <= fifo_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_packetizer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_packetizer_fsm
//  Description : Directed bench for uart_packetizer_fsm with a FIFO model and
//                a scoreboard of expected transmitted bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_packetizer_fsm;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fifo_data;
  logic        fifo_valid;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_count;

  logic [7:0]  fifo_q[$];
  logic [7:0]  sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit pop_pending = 1'b0;
  bit rnd_ready = 1'b0;
  int last_pop_cyc = 0;
  int first_valid_cyc = -1;
  int done_pulses = 0;
  int rd_during_tx = 0;
  int acc_cnt = 0;

  uart_packetizer_fsm #(
    .DATA_WIDTH    (8),
    .MAX_PAYLOAD   (8),
    .TIMEOUT_CYCLES(64),
    .SOF_BYTE      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_data (fifo_data),
    .fifo_valid(fifo_valid),
    .fifo_rd_en(fifo_rd_en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_count (pkt_count)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void refresh();
    fifo_valid = (fifo_q.size() > 0);
    fifo_data  = fifo_valid ? fifo_q[0] : 8'h00;
  endfunction

  function automatic bq_t seq(input logic [7:0] start, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(start + 8'(i));
    return q;
  endfunction

  task automatic push_bytes(input bq_t p);
    foreach (p[i]) fifo_q.push_back(p[i]);
    refresh();
  endtask

  // Independent model of the wire format: SOF, LEN, payload, LEN ^ xor(payload).
  task automatic expect_packet(input bq_t p);
    logic [7:0] c;
    c = 8'(p.size());
    sb.push_back(8'hA5);
    sb.push_back(8'(p.size()));
    foreach (p[i]) begin
      sb.push_back(p[i]);
      c = c ^ p[i];
    end
    sb.push_back(c);
  endtask

  task automatic begin_scn();
    first_valid_cyc = -1;
    done_pulses     = 0;
    rd_during_tx    = 0;
    acc_cnt         = 0;
  endtask

  // One clock: sample at negedge, then update FIFO model / ready after posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    pop_pending = fifo_rd_en && fifo_valid;
    if (pop_pending) last_pop_cyc = cyc;
    if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (tx_valid && fifo_rd_en) rd_during_tx++;
    if (pkt_done) done_pulses++;
    if (tx_valid && tx_ready) begin
      acc_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL tx_extra: observed byte %02h expected none", tx_data);
      end else begin
        check("tx_byte", {24'h0, tx_data}, {24'h0, sb.pop_front()});
      end
    end
    @(posedge clk);
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pending = 1'b0;
    if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
    refresh();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sb.size() == 0 && !busy) && n < budget);
    check({tag, "_done_in_budget"}, 32'(n < budget), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    tx_ready = 1'b1;
    refresh();

    // Reset state, including pop masking with a byte waiting in the FIFO.
    repeat (2) @(posedge clk);
    #1;
    push_bytes(seq(8'hEE, 1));
    #1;
    check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_tx_valid",   32'(tx_valid),   32'd0);
    check("rst_tx_data",    32'(tx_data),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_pkt_done",   32'(pkt_done),   32'd0);
    check("rst_pkt_count",  32'(pkt_count),  32'd0);
    fifo_q.delete();
    refresh();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Full packet, back-to-back bytes, tx_ready high.
    begin_scn();
    push_bytes(seq(8'h01, 8));
    expect_packet(seq(8'h01, 8));
    wait_done(200, "full");
    check("full_pkt_done_pulses", 32'(done_pulses), 32'd1);
    check("full_pkt_count",       32'(pkt_count),   32'd1);
    check("full_rd_during_tx",    32'(rd_during_tx), 32'd0);
    check("full_sof_latency",     32'(first_valid_cyc - last_pop_cyc), 32'd1);

    // Timeout closes a 3-byte packet 64 idle cycles after the last pop.
    begin_scn();
    push_bytes('{8'h10, 8'h20, 8'h30});
    expect_packet('{8'h10, 8'h20, 8'h30});
    wait_done(300, "tmo");
    check("tmo_sof_latency",  32'(first_valid_cyc - last_pop_cyc), 32'd65);
    check("tmo_pkt_count",    32'(pkt_count),   32'd2);
    check("tmo_done_pulses",  32'(done_pulses), 32'd1);

    // Backpressure: LEN held for 5 cycles, then random ready.
    begin_scn();
    tx_ready = 1'b0;
    push_bytes(seq(8'h01, 8));
    expect_packet(seq(8'h01, 8));
    n = 0;
    while (!tx_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_sof_seen", 32'(tx_valid), 32'd1);
    check("bp_sof_data", 32'(tx_data),  32'hA5);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_len_valid_held", 32'(tx_valid), 32'd1);
      check("bp_len_data_held",  32'(tx_data),  32'h08);
    end
    rnd_ready = 1'b1;
    wait_done(800, "bp");
    rnd_ready = 1'b0;
    tx_ready  = 1'b1;
    check("bp_pkt_count",    32'(pkt_count),    32'd3);
    check("bp_rd_during_tx", 32'(rd_during_tx), 32'd0);

    // Overflow split: 12 bytes become a full packet plus a timed-out one.
    begin_scn();
    push_bytes(seq(8'h01, 12));
    expect_packet(seq(8'h01, 8));
    expect_packet(seq(8'h09, 4));
    wait_done(500, "ovf");
    check("ovf_pkt_count",   32'(pkt_count),   32'd5);
    check("ovf_done_pulses", 32'(done_pulses), 32'd2);

    // Gaps of 63 idle cycles never close the packet; a pop on the would-be
    // expiry edge restarts the timer.
    begin_scn();
    expect_packet(seq(8'h41, 4));
    for (int i = 0; i < 4; i++) begin
      push_bytes(seq(8'h41 + 8'(i), 1));
      tick();
      if (i < 3) repeat (63) tick();
    end
    check("gap_still_busy",  32'(busy),     32'd1);
    check("gap_no_early_tx", 32'(tx_valid), 32'd0);
    wait_done(300, "gap");
    check("gap_sof_latency", 32'(first_valid_cyc - last_pop_cyc), 32'd65);
    check("gap_pkt_count",   32'(pkt_count), 32'd6);

    // Reset while the third payload byte is offered.
    begin_scn();
    push_bytes(seq(8'h51, 8));
    expect_packet(seq(8'h51, 8));
    n = 0;
    while (acc_cnt < 4 && n < 100) begin
      tick();
      n++;
    end
    check("mid_third_payload_valid", 32'(tx_valid), 32'd1);
    check("mid_third_payload_data",  32'(tx_data),  32'h53);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid",   32'(tx_valid),   32'd0);
    check("mid_rst_busy",       32'(busy),       32'd0);
    check("mid_rst_pkt_count",  32'(pkt_count),  32'd0);
    check("mid_rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    sb.delete();
    fifo_q.delete();
    refresh();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    begin_scn();
    push_bytes('{8'hAA, 8'hBB});
    expect_packet('{8'hAA, 8'hBB});
    wait_done(300, "post_rst");
    check("post_rst_pkt_count",   32'(pkt_count), 32'd1);
    check("post_rst_sof_latency", 32'(first_valid_cyc - last_pop_cyc), 32'd65);
    check("post_rst_sb_empty",    32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
